// File: rtl/boid_mem_arbiter.sv
// Round-robin arbiter sharing the single-port boid-state memory between the
// accelerator lanes and the VGA refill engine, with a read-return pipeline.
module boid_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_BOIDS = 2,
    parameter int ADDR_W    = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1,
    parameter int DATA_W    = 64,
    parameter int RD_LAT    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    input  logic                        refill_req,
    output logic                        refill_grant,
    input  logic                        refill_done,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int LANE_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {ARB, DRAIN, REFILL} state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [LANE_W-1:0]               r_rr_ptr;
    logic [LANE_W-1:0]               w_rr_ptr_nxt;
    logic [LANE_W:0]                 w_idx;
    logic [LANE_W-1:0]               w_sel;
    logic                            w_found;
    logic                            w_grant;
    logic                            w_rd_issue;
    logic                            w_pipe_clear;
    logic [RD_LAT-1:0]               r_rd_vld_p;
    logic [RD_LAT-1:0][LANE_W-1:0]   r_rd_lane_p;

    // First valid lane at or after the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (LANE_W+1)'(k);
            if (w_idx >= (LANE_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (LANE_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[LANE_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[LANE_W-1:0];
            end
        end
    end

    // A pending refill request beats every lane in the same cycle.
    assign w_grant    = (r_state == ARB) && !refill_req && !reset && w_found;
    assign w_rd_issue = w_grant && !req_we[w_sel];

    assign req_ready = w_grant ? (NUM_REQ'(1) << w_sel) : '0;
    assign mem_we    = w_grant && req_we[w_sel];
    assign mem_addr  = w_grant ? req_addr[w_sel*ADDR_W +: ADDR_W]  : '0;
    assign mem_wdata = w_grant ? req_wdata[w_sel*DATA_W +: DATA_W] : '0;

    assign w_rr_ptr_nxt = !w_grant                         ? r_rr_ptr :
                          (w_sel == LANE_W'(NUM_REQ - 1)) ? '0       :
                                                             w_sel + 1'b1;

    // Pipeline will be empty next cycle when only the last stage (or nothing) is occupied.
    always_comb begin
        w_pipe_clear = 1'b1;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            if (r_rd_vld_p[i]) begin
                w_pipe_clear = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB: begin
                if (refill_req) begin
                    w_state_nxt = w_pipe_clear ? REFILL : DRAIN;
                end
            end
            DRAIN: begin
                if (!refill_req) begin
                    w_state_nxt = ARB;
                end else if (w_pipe_clear) begin
                    w_state_nxt = REFILL;
                end
            end
            REFILL: begin
                if (refill_done) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ARB;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign refill_grant = (r_state == REFILL);

    // Read-return pipeline: stage _p[0] is loaded in the grant cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld_p <= '0;
        end else begin
            r_rd_vld_p[0] <= w_rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_vld_p[i] <= r_rd_vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_rd_lane_p[0] <= w_sel;
        for (int i = 1; i < RD_LAT; i++) begin
            r_rd_lane_p[i] <= r_rd_lane_p[i-1];
        end
    end

    assign rsp_valid = (r_rd_vld_p[RD_LAT-1] && !reset) ?
                       (NUM_REQ'(1) << r_rd_lane_p[RD_LAT-1]) : '0;
    assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_boid_mem_arbiter.sv
// Scoreboard bench for boid_mem_arbiter: a behavioural arbitration/memory model
// predicts grants and queues read responses; a monitor checks them as they return.
module tb_boid_mem_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int NUM_BOIDS = 2;
    localparam int ADDR_W    = 1;
    localparam int DATA_W    = 64;
    localparam int RD_LAT    = 2;

    localparam int M_ARB    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_REFILL = 2;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_we;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_wdata;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        refill_req;
    logic                        refill_grant;
    logic                        refill_done;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_we;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    // Refill engine's private write port into the memory model.
    logic                        rf_we;
    logic [ADDR_W-1:0]           rf_addr;
    logic [DATA_W-1:0]           rf_data;

    boid_mem_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .NUM_BOIDS(NUM_BOIDS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .refill_req  (refill_req),
        .refill_grant(refill_grant),
        .refill_done (refill_done),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous memory with RD_LAT cycles of read latency.
    logic [DATA_W-1:0] ram     [NUM_BOIDS];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (rf_we) ram[rf_addr] <= rf_data;
        rd_pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model state.
    typedef struct {
        int                lane;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              sbq [$];
    logic [DATA_W-1:0] ref_mem [NUM_BOIDS];
    int                m_ptr  = 0;
    int                m_mode = M_ARB;
    int                n_cmp  = 0;
    int                n_bad  = 0;
    bit                rq     = 1'b0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        reset       = 1'b0;
        req_valid   = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        refill_req  = 1'b0;
        refill_done = 1'b0;
        rf_we       = 1'b0;
        rf_addr     = '0;
        rf_data     = '0;
    endtask

    task automatic set_lane(input int i, input bit v, input bit we,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[i +: 1]            = v;
        req_we[i +: 1]               = we;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic rf_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rf_we       = 1'b1;
        rf_addr     = a;
        rf_data     = d;
        ref_mem[a]  = d;
    endtask

    // Inputs for the current cycle are already applied; predict, check at negedge,
    // advance the model, then step to just after the next rising edge.
    task automatic run_cycle();
        int                g;
        int                l;
        int                next_mode;
        bit                empty_after;
        bit                exp_rg;
        logic [NUM_REQ-1:0] exp_rdy;
        logic              exp_we;
        logic [ADDR_W-1:0] ga;
        logic [DATA_W-1:0] gd;
        exp_t              e;

        g         = -1;
        ga        = '0;
        gd        = '0;
        exp_we    = 1'b0;
        exp_rg    = (m_mode == M_REFILL);
        next_mode = m_mode;
        empty_after = 1'b1;
        foreach (sbq[i]) if (sbq[i].due >= cyc + 1) empty_after = 1'b0;

        if (!reset) begin
            if (m_mode == M_ARB) begin
                if (refill_req) begin
                    next_mode = empty_after ? M_REFILL : M_DRAIN;
                end else begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        l = (m_ptr + k) % NUM_REQ;
                        if (g < 0 && req_valid[l +: 1] == 1'b1) g = l;
                    end
                end
            end else if (m_mode == M_DRAIN) begin
                if (!refill_req) next_mode = M_ARB;
                else if (empty_after) next_mode = M_REFILL;
            end else begin
                if (refill_done) next_mode = M_ARB;
            end
        end

        exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
        if (g >= 0) begin
            exp_we = req_we[g +: 1];
            ga     = req_addr[g*ADDR_W +: ADDR_W];
            gd     = req_wdata[g*DATA_W +: DATA_W];
        end

        @(negedge clk);
        chk("req_ready", DATA_W'(req_ready), DATA_W'(exp_rdy));
        chk("mem_we", DATA_W'(mem_we), DATA_W'(exp_we));
        if (reset) begin
            chk("mem_addr_rst", DATA_W'(mem_addr), '0);
            chk("mem_wdata_rst", mem_wdata, '0);
            chk("rsp_valid_rst", DATA_W'(rsp_valid), '0);
        end else begin
            chk("refill_grant", DATA_W'(refill_grant), DATA_W'(exp_rg));
        end
        if (g >= 0) begin
            chk("mem_addr", DATA_W'(mem_addr), DATA_W'(ga));
            if (exp_we) chk("mem_wdata", mem_wdata, gd);
        end

        if (reset) begin
            sbq.delete();
            m_ptr  = 0;
            m_mode = M_ARB;
        end else begin
            if (g >= 0) begin
                if (exp_we) begin
                    ref_mem[ga] = gd;
                end else begin
                    e.lane = g;
                    e.data = ref_mem[ga];
                    e.due  = cyc + RD_LAT;
                    sbq.push_back(e);
                end
                m_ptr = (g + 1) % NUM_REQ;
            end
            m_mode = next_mode;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            run_cycle();
        end
    endtask

    // Response monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid !== '0) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", DATA_W'(rsp_valid), '0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_valid", DATA_W'(rsp_valid), DATA_W'(NUM_REQ'(1) << e.lane));
                    chk("rsp_rdata", rsp_rdata, e.data);
                    chk("rsp_cycle", DATA_W'(cyc), DATA_W'(e.due));
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk("rsp_missing", DATA_W'(rsp_valid), DATA_W'(NUM_REQ'(1) << e.lane));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Preload memory through the refill port while held in reset.
        for (int a = 0; a < NUM_BOIDS; a++) begin
            idle_inputs();
            reset = 1'b1;
            rf_write(ADDR_W'(a), (a == 1) ? 64'hAAAA_BBBB_CCCC_DDDD : 64'h0123_4567_89AB_CDEF);
            run_cycle();
        end
        idle_inputs();
        reset = 1'b1;
        run_cycle();
        idle_cycles(1);

        // Single read by lane 2.
        idle_inputs();
        set_lane(2, 1'b1, 1'b0, 1'b1, '0);
        run_cycle();
        idle_cycles(3);

        // Round-robin from a fresh pointer, then lane 1 drops out.
        idle_inputs();
        reset = 1'b1;
        run_cycle();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            for (int i = 0; i < NUM_REQ; i++)
                set_lane(i, !(c >= 6 && i == 1), 1'b0, ADDR_W'(i % NUM_BOIDS), '0);
            run_cycle();
        end
        idle_cycles(3);

        // Write by lane 0 followed immediately by a read of the same word by lane 3.
        idle_inputs();
        set_lane(0, 1'b1, 1'b1, 1'b0, 64'h1234);
        run_cycle();
        idle_inputs();
        set_lane(3, 1'b1, 1'b0, 1'b0, '0);
        run_cycle();
        idle_cycles(3);

        // Refill requested with two reads in flight; lanes keep asking throughout.
        idle_inputs();
        set_lane(0, 1'b1, 1'b0, 1'b1, '0);
        run_cycle();
        idle_inputs();
        set_lane(1, 1'b1, 1'b0, 1'b0, '0);
        run_cycle();
        for (int c = 2; c <= 8; c++) begin
            idle_inputs();
            for (int i = 0; i < NUM_REQ; i++) set_lane(i, 1'b1, 1'b0, 1'b0, '0);
            refill_req  = (c < 4);
            refill_done = (c == 8);
            if (c == 5) rf_write(1'b0, 64'h5555_6666_7777_8888);
            run_cycle();
        end
        idle_inputs();
        set_lane(2, 1'b1, 1'b0, 1'b0, '0);
        run_cycle();
        idle_cycles(3);

        // Refill request ties with all lanes on an empty pipeline.
        idle_inputs();
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 1'b1, 1'b0, 1'b1, '0);
        refill_req = 1'b1;
        run_cycle();
        idle_inputs();
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 1'b1, 1'b0, 1'b1, '0);
        refill_done = 1'b1;
        run_cycle();
        idle_cycles(3);

        // Reset lands while a read is in flight.
        idle_inputs();
        set_lane(1, 1'b1, 1'b0, 1'b1, '0);
        run_cycle();
        idle_inputs();
        reset = 1'b1;
        run_cycle();
        idle_inputs();
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 1'b1, 1'b0, 1'b0, '0);
        run_cycle();
        idle_cycles(3);

        // Randomized traffic with refill episodes and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            idle_inputs();
            reset = ($urandom_range(399, 0) == 0);
            for (int i = 0; i < NUM_REQ; i++)
                set_lane(i, $urandom_range(9, 0) < 6, $urandom_range(2, 0) == 0,
                         ADDR_W'($urandom_range(NUM_BOIDS-1, 0)), {$urandom, $urandom});
            if (m_mode == M_REFILL) begin
                rq          = 1'b0;
                refill_req  = $urandom_range(1, 0) == 1;
                refill_done = $urandom_range(4, 0) == 0;
                if ($urandom_range(1, 0) == 1)
                    rf_write(ADDR_W'($urandom_range(NUM_BOIDS-1, 0)), {$urandom, $urandom});
            end else begin
                rq          = rq ? ($urandom_range(7, 0) != 0) : ($urandom_range(19, 0) == 0);
                refill_req  = rq;
                refill_done = $urandom_range(11, 0) == 0;
            end
            run_cycle();
        end

        idle_cycles(RD_LAT + 3);
        chk("scoreboard_empty", DATA_W'(sbq.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
